// File: rtl/ir_bank_ctrl.sv
// Double-buffered impulse-response bank: streams a new IR into a shadow bank and swaps it into
// the active bank on a sample boundary. Define IR_BANK_CTRL_DEFAULT_IR_EN to reset to ir_weights.
module ir_bank_ctrl #(
  parameter int unsigned FXP_SIZE    = 16,
  parameter int unsigned WINDOW_SIZE = 256,
  parameter int unsigned GEN_WIDTH   = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_load_start,
  input  logic                            i_cfg_valid,
  output logic                            o_cfg_ready,
  input  logic [FXP_SIZE-1:0]             i_cfg_data,
  input  logic                            i_cfg_last,
  input  logic                            i_sample_valid,
  output logic [WINDOW_SIZE*FXP_SIZE-1:0] o_ir,
  output logic                            o_busy,
  output logic                            o_swap_done,
  output logic                            o_err,
  output logic [GEN_WIDTH-1:0]            o_gen
);

  localparam int unsigned PtrW = (WINDOW_SIZE > 1) ? $clog2(WINDOW_SIZE) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(WINDOW_SIZE - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StArmed} state_e;

  state_e                                 state_q, state_d;
  logic [PtrW-1:0]                        wptr_q, wptr_d;
  logic [WINDOW_SIZE-1:0][FXP_SIZE-1:0]   shadow_q, active_q, default_ir;
  logic                                   ready_q, swap_done_q, err_q;
  logic [GEN_WIDTH-1:0]                   gen_q;
  logic                                   accept, swap, err_d;

`ifdef IR_BANK_CTRL_DEFAULT_IR_EN
  ir_weights #(
    .test_vector_len(WINDOW_SIZE),
    .test_word_width(FXP_SIZE)
  ) u_ir_weights (
    .o_weights(default_ir)
  );
`else
  assign default_ir = '0;
`endif

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    accept  = 1'b0;
    swap    = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_load_start) begin
          state_d = StLoad;
          wptr_d  = '0;
        end
      end
      StLoad: begin
        // A restart wins over a word offered in the same cycle; that word is dropped.
        if (i_load_start) begin
          wptr_d = '0;
        end else if (i_cfg_valid && ready_q) begin
          accept = 1'b1;
          wptr_d = wptr_q + 1'b1;
          if ((wptr_q == LastPtr) || i_cfg_last) begin
            wptr_d = '0;
            if ((wptr_q == LastPtr) && i_cfg_last) begin
              state_d = StArmed;
            end else begin
              state_d = StIdle;
              err_d   = 1'b1;
            end
          end
        end
      end
      StArmed: begin
        if (i_load_start) begin
          state_d = StLoad;
          wptr_d  = '0;
        end else if (i_sample_valid) begin
          swap    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      wptr_q      <= '0;
      shadow_q    <= '0;
      active_q    <= default_ir;
      ready_q     <= 1'b0;
      swap_done_q <= 1'b0;
      err_q       <= 1'b0;
      gen_q       <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      ready_q     <= (state_d == StLoad);
      swap_done_q <= swap;
      err_q       <= err_d;
      if (accept) begin
        shadow_q[wptr_q] <= i_cfg_data;
      end
      if (swap) begin
        active_q <= shadow_q;
        gen_q    <= gen_q + 1'b1;
      end
    end
  end

  assign o_ir        = active_q;
  assign o_busy      = (state_q != StIdle);
  assign o_cfg_ready = ready_q;
  assign o_swap_done = swap_done_q;
  assign o_err       = err_q;
  assign o_gen       = gen_q;

endmodule

// File: tb/tb_ir_bank_ctrl.sv
// Scoreboard bench for ir_bank_ctrl: stimulus queues expected swap/error events, a negedge
// monitor pops and checks them whenever the DUT pulses o_swap_done or o_err.
module tb_ir_bank_ctrl;

  localparam int unsigned F = 16;
  localparam int unsigned W = 4;
  localparam int unsigned G = 8;

  logic           clk = 1'b0;
  logic           rst, i_load_start, i_cfg_valid, i_cfg_last, i_sample_valid;
  logic [F-1:0]   i_cfg_data;
  logic           o_cfg_ready, o_busy, o_swap_done, o_err;
  logic [W*F-1:0] o_ir;
  logic [G-1:0]   o_gen;

  typedef struct {
    bit           is_err;
    logic [W*F-1:0] ir;
    logic [G-1:0] gen;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  failures = 0;

  ir_bank_ctrl #(.FXP_SIZE(F), .WINDOW_SIZE(W), .GEN_WIDTH(G)) dut (
    .clk(clk), .rst(rst), .i_load_start(i_load_start), .i_cfg_valid(i_cfg_valid),
    .o_cfg_ready(o_cfg_ready), .i_cfg_data(i_cfg_data), .i_cfg_last(i_cfg_last),
    .i_sample_valid(i_sample_valid), .o_ir(o_ir), .o_busy(o_busy),
    .o_swap_done(o_swap_done), .o_err(o_err), .o_gen(o_gen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W*F-1:0] act, input logic [W*F-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && (o_swap_done || o_err)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event actual=swap%0b_err%0b required=none", o_swap_done, o_err);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk(e.is_err ? "ev_err_pulse" : "ev_swap_pulse", {o_err, o_swap_done},
            e.is_err ? 64'd2 : 64'd1);
        chk("ev_ir", o_ir, e.ir);
        chk("ev_gen", 64'(o_gen), 64'(e.gen));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start();
    i_load_start = 1'b1;
    tick();
    i_load_start = 1'b0;
  endtask

  task automatic word(input logic [F-1:0] d, input logic last);
    i_cfg_valid = 1'b1;
    i_cfg_data  = d;
    i_cfg_last  = last;
    tick();
    i_cfg_valid = 1'b0;
    i_cfg_last  = 1'b0;
  endtask

  task automatic strobe();
    i_sample_valid = 1'b1;
    tick();
    i_sample_valid = 1'b0;
  endtask

  task automatic push(input bit is_err, input logic [W*F-1:0] ir, input logic [G-1:0] gen);
    ev_t e;
    e.is_err = is_err;
    e.ir     = ir;
    e.gen    = gen;
    exp_q.push_back(e);
  endtask

  logic [W*F-1:0] ir_a, ir_b, ir_c, ir_w;

  initial begin
    rst = 1'b1; i_load_start = 1'b0; i_cfg_valid = 1'b0; i_cfg_last = 1'b0;
    i_sample_valid = 1'b0; i_cfg_data = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_ir", o_ir, '0);
    chk("rst_flags", {o_busy, o_cfg_ready, o_swap_done, o_err}, 64'd0);
    chk("rst_gen", 64'(o_gen), 64'd0);

    // Nominal load
    ir_a = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
    start();
    chk("load_busy_ready", {o_busy, o_cfg_ready}, 64'd3);
    word(16'h0100, 1'b0); word(16'h0200, 1'b0); word(16'h0300, 1'b0); word(16'h0400, 1'b1);
    chk("armed_busy_ready", {o_busy, o_cfg_ready}, 64'd2);
    tick(); tick(); tick();
    chk("ir_before_strobe", o_ir, '0);
    push(1'b0, ir_a, 8'd1);
    strobe();
    tick();
    chk("after_swap_idle", {o_busy, o_swap_done}, 64'd0);

    // Short stream: last on third word
    start();
    word(16'h0111, 1'b0); word(16'h0222, 1'b0);
    push(1'b1, ir_a, 8'd1);
    word(16'h0333, 1'b1);
    tick();
    chk("short_idle", {o_busy, o_cfg_ready, o_err}, 64'd0);
    strobe(); tick(); strobe(); tick();
    chk("short_no_swap_ir", o_ir, ir_a);
    chk("short_gen", 64'(o_gen), 64'd1);

    // Long stream: no last on fourth word, then a stray fifth word
    start();
    word(16'h0AAA, 1'b0); word(16'h0BBB, 1'b0); word(16'h0CCC, 1'b0);
    push(1'b1, ir_a, 8'd1);
    word(16'h0DDD, 1'b0);
    chk("long_ready_low", {o_busy, o_cfg_ready}, 64'd0);
    word(16'h0EEE, 1'b1);
    tick();
    chk("long_still_idle", 64'(o_busy), 64'd0);
    strobe(); tick();
    chk("long_no_swap_ir", o_ir, ir_a);

    // Restart mid-load, with a word dropped by the concurrent start
    ir_b = {16'h000D, 16'h000C, 16'h000B, 16'h000A};
    start();
    word(16'h1111, 1'b0); word(16'h2222, 1'b0);
    i_load_start = 1'b1;
    word(16'hDEAD, 1'b0);
    i_load_start = 1'b0;
    word(16'h000A, 1'b0); word(16'h000B, 1'b0); word(16'h000C, 1'b0); word(16'h000D, 1'b1);
    push(1'b0, ir_b, 8'd2);
    strobe();
    tick();

    // Cancel an armed swap with simultaneous start and strobe
    ir_c = {16'h0008, 16'h0007, 16'h0006, 16'h0005};
    start();
    word(16'h0011, 1'b0); word(16'h0022, 1'b0); word(16'h0033, 1'b0); word(16'h0044, 1'b1);
    i_load_start = 1'b1;
    strobe();
    i_load_start = 1'b0;
    chk("cancel_in_load", {o_busy, o_cfg_ready}, 64'd3);
    chk("cancel_ir", o_ir, ir_b);
    chk("cancel_gen", 64'(o_gen), 64'd2);
    word(16'h0005, 1'b0); word(16'h0006, 1'b0); word(16'h0007, 1'b0); word(16'h0008, 1'b1);
    push(1'b0, ir_c, 8'd3);
    strobe();
    tick();

    // Reset while armed
    start();
    word(16'h0099, 1'b0); word(16'h0098, 1'b0); word(16'h0097, 1'b0); word(16'h0096, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    strobe(); tick();
    chk("rst_armed_ir", o_ir, '0);
    chk("rst_armed_flags", {o_busy, o_cfg_ready, o_swap_done, o_err}, 64'd0);
    chk("rst_armed_gen", 64'(o_gen), 64'd0);

    // 256 back-to-back swaps: generation counter wraps to zero
    for (int i = 0; i < 256; i++) begin
      for (int k = 0; k < 4; k++) ir_w[k*16 +: 16] = 16'(i * 4 + k);
      start();
      for (int k = 0; k < 4; k++) word(ir_w[k*16 +: 16], k == 3);
      push(1'b0, ir_w, 8'(i + 1));
      strobe();
      if (i == 254) begin
        tick();
        chk("gen_255", 64'(o_gen), 64'd255);
      end
    end
    tick();
    chk("gen_wrap", 64'(o_gen), 64'd0);
    tick(); tick();
    chk("pending_events", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
